// File: rtl/sram_scan_burst_ctrl.sv
// Serial scan controller for the SCPU I/O control chain. Loads address+data
// frames from Avalon-MM registers, shifts them LSB-first on a divided serial
// clock and captures the returning chain contents for readback. Bursts repeat
// the frame with an auto-incrementing address.
`timescale 1ns/1ps
module sram_scan_burst_ctrl #(
  parameter int MEM_DATA_WIDTH = 8,
  parameter int MEM_ADDR_WIDTH = 9,
  parameter int FRAME_BITS     = MEM_ADDR_WIDTH + MEM_DATA_WIDTH,
  parameter int AVS_WIDTH      = 32,
  parameter int DIV_WIDTH      = 8
) (
  input  logic                 csi_clk,
  input  logic                 rsi_reset_n,
  input  logic [AVS_WIDTH-1:0] avs_cpuctrl_writedata,
  input  logic                 avs_cpuctrl_write,
  output logic [AVS_WIDTH-1:0] avs_cpustat_readdata,
  input  logic [AVS_WIDTH-1:0] avs_sram_addr_writedata,
  input  logic                 avs_sram_addr_write,
  input  logic [AVS_WIDTH-1:0] avs_sram_data_writedata,
  input  logic                 avs_sram_data_write,
  output logic [AVS_WIDTH-1:0] avs_sram_addr_readdata,
  output logic [AVS_WIDTH-1:0] avs_sram_data_readdata,
  output logic                 coe_ctrl_bgn_export,
  output logic [1:0]           coe_ctrl_mod_export,
  output logic                 coe_ctrl_load_export,
  output logic                 coe_ctrl_si_export,
  output logic                 coe_ctrl_sclk_export,
  input  logic                 coe_ctrl_so_export,
  input  logic                 coe_ctrl_rdy_export
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_CAPTURE
  } state_t;

  state_t state, state_nxt;

  // Host-visible registers
  logic                      bgn_q;
  logic [1:0]                mode_q;
  logic [DIV_WIDTH-1:0]      div_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [MEM_DATA_WIDTH-1:0] data_q;
  logic                      done_q;

  // Burst bookkeeping
  logic [7:0]                remaining;
  logic [MEM_ADDR_WIDTH-1:0] addr_cnt;
  logic                      addr_pend;

  // Shift datapath
  logic [FRAME_BITS-1:0]     shift_q;
  logic [FRAME_BITS-1:0]     capture_q;
  logic [7:0]                bit_cnt;
  logic [DIV_WIDTH-1:0]      div_frame;
  logic [DIV_WIDTH-1:0]      div_cnt;
  logic                      so_bit;

  logic                      start_accept;
  logic                      phase_last;
  logic                      burst_next;
  logic [MEM_ADDR_WIDTH-1:0] addr_wr_val;

  assign start_accept = avs_cpuctrl_write && avs_cpuctrl_writedata[1] && (state == S_IDLE);
  assign phase_last   = (div_cnt == div_frame);
  assign burst_next   = (state == S_CAPTURE) && (remaining != 8'd0);
  assign addr_wr_val  = avs_sram_addr_writedata[MEM_ADDR_WIDTH-1:0];

  // Bits of the Avalon words that carry no field
  logic unused_wdata;
  assign unused_wdata = ^{avs_cpuctrl_writedata[AVS_WIDTH-1:24],
                          avs_cpuctrl_writedata[7:4],
                          avs_sram_addr_writedata[AVS_WIDTH-1:MEM_ADDR_WIDTH],
                          avs_sram_data_writedata[AVS_WIDTH-1:MEM_DATA_WIDTH]};

  // State register
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) state <= S_IDLE;
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of the order of statements or blocks.
    else              state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // and no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (start_accept) state_nxt = S_LOAD;
      S_LOAD:     state_nxt = S_SHIFT_LO;
      S_SHIFT_LO: if (phase_last) state_nxt = S_SHIFT_HI;
      S_SHIFT_HI: if (phase_last) state_nxt = (bit_cnt == 8'd1) ? S_CAPTURE : S_SHIFT_LO;
      S_CAPTURE:  state_nxt = (remaining == 8'd0) ? S_IDLE : S_LOAD;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Serial-side outputs decoded from the state
  always_comb begin
    coe_ctrl_load_export = 1'b0;
    coe_ctrl_sclk_export = 1'b0;
    coe_ctrl_si_export   = 1'b0;
    unique case (state)
      S_LOAD:     coe_ctrl_load_export = 1'b1;
      S_SHIFT_LO: coe_ctrl_si_export   = shift_q[0];
      S_SHIFT_HI: begin
        coe_ctrl_sclk_export = 1'b1;
        coe_ctrl_si_export   = shift_q[0];
      end
      default: ;
    endcase
  end

  // Host register file: BGN/MODE/DIV follow every control write
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      // NOTE: these are plain registers, not a memory array, so resetting
      // them is cheap and gives software a defined state after reset.
      bgn_q  <= 1'b0;
      mode_q <= 2'b00;
      div_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (avs_cpuctrl_write) begin
        bgn_q  <= avs_cpuctrl_writedata[0];
        mode_q <= avs_cpuctrl_writedata[3:2];
        div_q  <= avs_cpuctrl_writedata[16 +: DIV_WIDTH];
      end
      if (avs_sram_addr_write) addr_q <= addr_wr_val;
      if (avs_sram_data_write) data_q <= avs_sram_data_writedata[MEM_DATA_WIDTH-1:0];
    end
  end

  // Burst control: frame count, address counter and sticky DONE
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      done_q    <= 1'b0;
      remaining <= '0;
      addr_cnt  <= '0;
      addr_pend <= 1'b0;
    end else begin
      if (start_accept) begin
        done_q    <= 1'b0;
        remaining <= avs_cpuctrl_writedata[15:8];
        // A same-cycle address write wins over the stored address.
        addr_cnt  <= avs_sram_addr_write ? addr_wr_val : addr_q;
        addr_pend <= 1'b0;
      end else if (burst_next) begin
        remaining <= remaining - 8'd1;
        // An address written mid-burst redirects the next frame; otherwise
        // the counter steps and wraps at the address width.
        if (avs_sram_addr_write)  addr_cnt <= addr_wr_val;
        else if (addr_pend)       addr_cnt <= addr_q;
        else                      addr_cnt <= addr_cnt + 1'b1;
        addr_pend <= 1'b0;
      end else begin
        if (state == S_CAPTURE) done_q <= 1'b1;
        if (avs_sram_addr_write && state != S_IDLE) addr_pend <= 1'b1;
      end
    end
  end

  // Shift engine: frame load, divided bit timing and readback capture
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      shift_q   <= '0;
      capture_q <= '0;
      bit_cnt   <= '0;
      div_frame <= '0;
      div_cnt   <= '0;
      so_bit    <= 1'b0;
    end else begin
      unique case (state)
        S_LOAD: begin
          shift_q   <= {addr_cnt, data_q};
          bit_cnt   <= 8'(FRAME_BITS);
          div_frame <= div_q;
          div_cnt   <= '0;
        end
        S_SHIFT_LO: begin
          if (phase_last) begin
            so_bit  <= coe_ctrl_so_export;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_SHIFT_HI: begin
          if (phase_last) begin
            shift_q <= {so_bit, shift_q[FRAME_BITS-1:1]};
            bit_cnt <= bit_cnt - 8'd1;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_CAPTURE: capture_q <= shift_q;
        default: ;
      endcase
    end
  end

  // Avalon read views and chip control levels
  always_comb begin
    avs_cpustat_readdata       = '0;
    avs_cpustat_readdata[0]    = coe_ctrl_rdy_export;
    avs_cpustat_readdata[1]    = (state != S_IDLE);
    avs_cpustat_readdata[2]    = done_q;
    avs_cpustat_readdata[15:8] = remaining;
  end

  assign avs_sram_addr_readdata = AVS_WIDTH'(capture_q[FRAME_BITS-1:MEM_DATA_WIDTH]);
  assign avs_sram_data_readdata = AVS_WIDTH'(capture_q[MEM_DATA_WIDTH-1:0]);
  assign coe_ctrl_bgn_export    = bgn_q;
  assign coe_ctrl_mod_export    = mode_q;

endmodule

// File: tb/tb_sram_scan_burst_ctrl.sv
// Self-checking bench for sram_scan_burst_ctrl. A transaction-level model
// expands each burst into the expected per-cycle serial waveform and status,
// which one compare process checks on every busy cycle.
`timescale 1ns/1ps
module tb_sram_scan_burst_ctrl;

  logic        csi_clk = 1'b0;
  logic        rsi_reset_n = 1'b0;
  logic [31:0] avs_cpuctrl_writedata = '0;
  logic        avs_cpuctrl_write = 1'b0;
  logic [31:0] avs_cpustat_readdata;
  logic [31:0] avs_sram_addr_writedata = '0;
  logic        avs_sram_addr_write = 1'b0;
  logic [31:0] avs_sram_data_writedata = '0;
  logic        avs_sram_data_write = 1'b0;
  logic [31:0] avs_sram_addr_readdata;
  logic [31:0] avs_sram_data_readdata;
  logic        coe_ctrl_bgn_export;
  logic [1:0]  coe_ctrl_mod_export;
  logic        coe_ctrl_load_export;
  logic        coe_ctrl_si_export;
  logic        coe_ctrl_sclk_export;
  logic        coe_ctrl_so_export;
  logic        coe_ctrl_rdy_export = 1'b0;

  // 0: so looped back from si, 1: so held 0, 2: so held 1
  logic [1:0]  so_mode = 2'd0;
  assign coe_ctrl_so_export = (so_mode == 2'd0) ? coe_ctrl_si_export : (so_mode == 2'd2);

  sram_scan_burst_ctrl dut (
    .csi_clk                 (csi_clk),
    .rsi_reset_n             (rsi_reset_n),
    .avs_cpuctrl_writedata   (avs_cpuctrl_writedata),
    .avs_cpuctrl_write       (avs_cpuctrl_write),
    .avs_cpustat_readdata    (avs_cpustat_readdata),
    .avs_sram_addr_writedata (avs_sram_addr_writedata),
    .avs_sram_addr_write     (avs_sram_addr_write),
    .avs_sram_data_writedata (avs_sram_data_writedata),
    .avs_sram_data_write     (avs_sram_data_write),
    .avs_sram_addr_readdata  (avs_sram_addr_readdata),
    .avs_sram_data_readdata  (avs_sram_data_readdata),
    .coe_ctrl_bgn_export     (coe_ctrl_bgn_export),
    .coe_ctrl_mod_export     (coe_ctrl_mod_export),
    .coe_ctrl_load_export    (coe_ctrl_load_export),
    .coe_ctrl_si_export      (coe_ctrl_si_export),
    .coe_ctrl_sclk_export    (coe_ctrl_sclk_export),
    .coe_ctrl_so_export      (coe_ctrl_so_export),
    .coe_ctrl_rdy_export     (coe_ctrl_rdy_export)
  );

  always #5 csi_clk = ~csi_clk;

  typedef struct packed {
    logic       load;
    logic       sclk;
    logic       si;
    logic [7:0] rem;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          busy_cnt = 0;
  int          load_cnt = 0;
  logic        exp_bgn = 1'b0;
  logic [1:0]  exp_mod = 2'b00;
  logic [16:0] exp_cap = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ctrl_word(input logic bgn, input logic start,
                                            input logic [1:0] mode, input logic [7:0] len_m1,
                                            input logic [7:0] div);
    return {8'h00, div, len_m1, 4'h0, mode, start, bgn};
  endfunction

  // Model: expand a burst into the cycle-by-cycle waveform it must produce.
  task automatic push_burst(input logic [8:0] addr, input logic [7:0] data, input int n,
                            input int d0, input int dn);
    int d;
    logic [16:0] word;
    for (int f = 0; f < n; f++) begin
      d    = (f == 0) ? d0 : dn;
      word = {9'(addr + f), data};
      exp_q.push_back('{load: 1'b1, sclk: 1'b0, si: 1'b0, rem: 8'(n - 1 - f)});
      for (int b = 0; b < 17; b++)
        for (int k = 0; k < 2 * (d + 1); k++)
          exp_q.push_back('{load: 1'b0, sclk: (k >= d + 1), si: word[b], rem: 8'(n - 1 - f)});
      exp_q.push_back('{load: 1'b0, sclk: 1'b0, si: 1'b0, rem: 8'(n - 1 - f)});
      exp_cap = (so_mode == 2'd0) ? word : (so_mode == 2'd2) ? 17'h1FFFF : 17'h0;
    end
  endtask

  // Compare process: every cycle the model says the controller is busy
  always @(negedge csi_clk) begin
    if (coe_ctrl_load_export) load_cnt++;
    if (avs_cpustat_readdata[1]) busy_cnt++;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check("cycle",
            {26'h0, coe_ctrl_load_export, coe_ctrl_sclk_export, coe_ctrl_si_export,
             coe_ctrl_bgn_export, coe_ctrl_mod_export, avs_cpustat_readdata},
            {26'h0, cur.load, cur.sclk, cur.si, exp_bgn, exp_mod,
             16'h0, cur.rem, 5'h0, 1'b0, 1'b1, coe_ctrl_rdy_export});
    end
  end

  // Write address, data and a START control word in the same cycle.
  task automatic start_burst(input logic [8:0] addr, input logic [7:0] data,
                             input logic [7:0] len_m1, input logic [7:0] div,
                             input logic bgn, input logic [1:0] mode,
                             input logic [1:0] som, input int dn);
    @(posedge csi_clk); #1;
    so_mode                 = som;
    avs_sram_addr_writedata = 32'(addr);
    avs_sram_addr_write     = 1'b1;
    avs_sram_data_writedata = 32'(data);
    avs_sram_data_write     = 1'b1;
    avs_cpuctrl_writedata   = ctrl_word(bgn, 1'b1, mode, len_m1, div);
    avs_cpuctrl_write       = 1'b1;
    load_cnt = 0;
    busy_cnt = 0;
    @(posedge csi_clk); #1;
    avs_sram_addr_write = 1'b0;
    avs_sram_data_write = 1'b0;
    avs_cpuctrl_write   = 1'b0;
    exp_bgn = bgn;
    exp_mod = mode;
    push_burst(addr, data, int'(len_m1) + 1, int'(div), dn);
  endtask

  // Wait (bounded) for the model to drain, then check the idle result.
  task automatic finish_burst(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(posedge csi_clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: actual %0d cycles left required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge csi_clk);
    check({name, "_stat"}, avs_cpustat_readdata, {29'h0, 1'b1, 1'b0, coe_ctrl_rdy_export});
    check({name, "_rb_addr"}, avs_sram_addr_readdata, {23'h0, exp_cap[16:8]});
    check({name, "_rb_data"}, avs_sram_data_readdata, {24'h0, exp_cap[7:0]});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    check("reset_pins", {coe_ctrl_load_export, coe_ctrl_sclk_export, coe_ctrl_si_export,
                         coe_ctrl_bgn_export, coe_ctrl_mod_export}, 6'h0);
    check("reset_stat", avs_cpustat_readdata, 32'h0);
    check("reset_rb", {avs_sram_addr_readdata, avs_sram_data_readdata}, 64'h0);
    #11 rsi_reset_n = 1'b1;
    coe_ctrl_rdy_export = 1'b1;

    // Single frame, DIV=0, looped back
    start_burst(9'h1A5, 8'h3C, 8'd0, 8'd0, 1'b0, 2'd0, 2'd0, 0);
    finish_burst("t1");
    check("t1_addr_lit", avs_sram_addr_readdata, 32'h1A5);
    check("t1_data_lit", avs_sram_data_readdata, 32'h3C);
    check("t1_busy_cycles", busy_cnt, 36);
    check("t1_loads", load_cnt, 1);
    check("t1_stat_lit", avs_cpustat_readdata, 32'h5);

    // DIV=3: 8-cycle sclk period, 1+136+1 busy cycles
    start_burst(9'h0F0, 8'h81, 8'd0, 8'd3, 1'b1, 2'd1, 2'd0, 3);
    finish_burst("t2");
    check("t2_busy_cycles", busy_cnt, 138);

    // Three-frame burst wrapping the address
    start_burst(9'h1FE, 8'h5A, 8'd2, 8'd0, 1'b0, 2'd3, 2'd0, 0);
    finish_burst("t3");
    check("t3_loads", load_cnt, 3);
    check("t3_last_addr_lit", avs_sram_addr_readdata, 32'h000);
    check("t3_busy_cycles", busy_cnt, 108);

    // so held high, then low
    start_burst(9'h012, 8'h34, 8'd0, 8'd0, 1'b0, 2'd0, 2'd2, 0);
    finish_burst("t4a");
    check("t4a_lit", {avs_sram_addr_readdata, avs_sram_data_readdata}, {32'h1FF, 32'hFF});
    start_burst(9'h1FF, 8'hFF, 8'd0, 8'd0, 1'b0, 2'd0, 2'd1, 0);
    finish_burst("t4b");
    check("t4b_lit", {avs_sram_addr_readdata, avs_sram_data_readdata}, 64'h0);

    // START while busy: ignored; BGN/MODE follow; DIV applies to next frame
    so_mode = 2'd0;
    start_burst(9'h010, 8'hA5, 8'd1, 8'd0, 1'b0, 2'd0, 2'd0, 1);
    repeat (10) @(posedge csi_clk);
    #1;
    avs_cpuctrl_writedata = ctrl_word(1'b1, 1'b1, 2'd2, 8'd5, 8'd1);
    avs_cpuctrl_write     = 1'b1;
    @(posedge csi_clk); #1;
    avs_cpuctrl_write = 1'b0;
    exp_bgn = 1'b1;
    exp_mod = 2'd2;
    finish_burst("t5");
    check("t5_loads", load_cnt, 2);
    check("t5_busy_cycles", busy_cnt, 106);
    check("t5_pins_lit", {coe_ctrl_bgn_export, coe_ctrl_mod_export}, 3'b110);

    // Asynchronous reset mid-shift, then a fresh burst
    start_burst(9'h0AA, 8'h66, 8'd1, 8'd3, 1'b1, 2'd3, 2'd0, 3);
    repeat (20) @(posedge csi_clk);
    #1 exp_q.delete();
    #2 rsi_reset_n = 1'b0;
    #1;
    check("t6_rst_pins", {coe_ctrl_load_export, coe_ctrl_sclk_export, coe_ctrl_si_export,
                          coe_ctrl_bgn_export, coe_ctrl_mod_export}, 6'h0);
    check("t6_rst_stat", avs_cpustat_readdata, {31'h0, coe_ctrl_rdy_export});
    check("t6_rst_rb", {avs_sram_addr_readdata, avs_sram_data_readdata}, 64'h0);
    exp_bgn = 1'b0;
    exp_mod = 2'd0;
    #4 rsi_reset_n = 1'b1;
    start_burst(9'h07F, 8'hC3, 8'd0, 8'd1, 1'b0, 2'd1, 2'd0, 1);
    finish_burst("t6");
    check("t6_lit", {avs_sram_addr_readdata, avs_sram_data_readdata}, {32'h07F, 32'hC3});
    check("t6_busy_cycles", busy_cnt, 70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_scan_burst_ctrl.md
Name: sram_scan_burst_ctrl

Overview:
Parametrised serial scan controller that loads, shifts and reads back SRAM address+data frames on the on-chip SCPU I/O control chain. Sits between Avalon-MM slave registers (Nios side) and the chip's serial pins. It adds three things: a programmable serial clock divider, multi-frame bursts with address auto-increment, and busy/done status with per-frame readback capture.

Parameters:
MEM_DATA_WIDTH, 8, SRAM data bits per frame.
MEM_ADDR_WIDTH, 9, SRAM address bits per frame.
FRAME_BITS, MEM_ADDR_WIDTH+MEM_DATA_WIDTH, shift frame length; must be ≤ 255.
AVS_WIDTH, 32, Avalon data width.
DIV_WIDTH, 8, width of the serial clock divider field.

Ports:
csi_clk  in  1  system clock
rsi_reset_n  in  1  asynchronous active-low reset
avs_cpuctrl_writedata  in  AVS_WIDTH  control word: [0] BGN, [1] START, [3:2] MODE, [15:8] BURST_LEN-1, [23:16] DIV
avs_cpuctrl_write  in  1  control write strobe
avs_cpustat_readdata  out  AVS_WIDTH  [0] RDY pin, [1] BUSY, [2] DONE, [15:8] frames remaining, rest 0
avs_sram_addr_writedata  in  AVS_WIDTH  start address, low MEM_ADDR_WIDTH bits used
avs_sram_addr_write  in  1  address write strobe
avs_sram_data_writedata  in  AVS_WIDTH  frame data, low MEM_DATA_WIDTH bits used
avs_sram_data_write  in  1  data write strobe
avs_sram_addr_readdata  out  AVS_WIDTH  address field of last captured frame, zero-extended
avs_sram_data_readdata  out  AVS_WIDTH  data field of last captured frame, zero-extended
coe_ctrl_bgn_export  out  1  BGN level to chip
coe_ctrl_mod_export  out  2  MODE to chip
coe_ctrl_load_export  out  1  one-cycle parallel-load pulse
coe_ctrl_si_export  out  1  serial data out (LSB first)
coe_ctrl_sclk_export  out  1  divided serial clock
coe_ctrl_so_export  in  1  serial data in
coe_ctrl_rdy_export  in  1  chip ready

Behaviour:
- Reset (async): all outputs 0. State IDLE. All registers 0: shift, capture, count, divider.
- Control write: BGN, MODE and DIV are latched on every write. BURST_LEN and START are acted on only in IDLE. A START in BUSY is ignored; no other field is affected by it.
- Address/data writes are accepted at any time. A write during BUSY takes effect at the next frame load.
- FSM: IDLE -> LOAD on START=1 in IDLE.
  - Same edge: DONE cleared, remaining := BURST_LEN field, addr_cnt := address reg.
- LOAD (1 cycle): load_export=1; shift := {addr_cnt, data_reg}; bit_cnt := FRAME_BITS; -> SHIFT_LO.
- SHIFT_LO: sclk=0 for DIV+1 cycles, si = shift[0]. Last cycle samples so into so_bit -> SHIFT_HI.
- SHIFT_HI: sclk=1 for DIV+1 cycles. Last cycle: shift := {so_bit, shift[FRAME_BITS-1:1]}, bit_cnt−1.
  - bit_cnt reaches 0 -> CAPTURE. Otherwise -> SHIFT_LO.
- One bit takes 2·(DIV+1) cycles. A frame takes 1 + FRAME_BITS·2·(DIV+1) cycles, plus 1 CAPTURE cycle.
- CAPTURE (1 cycle): readback regs := shift.
  - remaining=0: DONE:=1, -> IDLE.
  - Otherwise: remaining−1; addr_cnt+1, wrapping modulo 2^MEM_ADDR_WIDTH; -> LOAD.
- BUSY=1 in every state except IDLE. DONE is sticky until the next accepted START.
- The data register is reused for every frame of a burst. Only the address increments.
- Divider value is sampled at frame LOAD. A DIV change mid-frame applies from the next frame.
- Reset asserted mid-burst: immediate abort, all state to reset values, no DONE.
- Simultaneous START and address write in IDLE: the new address is used.

Test Plan:
1. Reset, addr=0x1A5, data=0x3C, DIV=0, BURST_LEN-1=0, START -> load pulse 1 cycle; si sequence is LSB-first of 0x1A53C over 17 bits. With so tied to si, readback addr=0x1A5, data=0x3C. DONE=1 after 1+34+1 cycles.
2. DIV=3 -> sclk period 8 cycles, 50% duty. Frame duration 1+136 cycles; BUSY=1 throughout.
3. Burst: addr=0x1FE, BURST_LEN-1=2 -> three load pulses with frame addresses 0x1FE, 0x1FF, 0x000 (wrap). Status[15:8] reads 2, 1, 0; DONE only after the third frame.
4. so forced 1 -> readback addr=0x1FF, data=0xFF. so forced 0 -> both 0.
5. START while BUSY -> no extra load pulse, count unchanged. MODE/BGN write mid-frame -> outputs update next cycle.
6. rsi_reset_n pulsed low mid-shift (not clock-aligned) -> outputs 0 immediately, state IDLE, DONE=0; a new START works normally.
